// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

    localparam int WIDTH = 4;
    localparam int REM_WIDTH = 5;
    localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_subtractor.sv
// REM_WIDTH-bit a-b built as a ripple chain of full-adder cells (a + ~b + 1).
module ripple_subtractor
    import div_pkg::*;
(
    input  logic [REM_WIDTH-1:0] a,
    input  logic [REM_WIDTH-1:0] b,
    output logic [REM_WIDTH-1:0] diff,
    output logic                 borrow
);

    logic [REM_WIDTH:0] carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < REM_WIDTH; gi++) begin : g_cell
            logic b_inv;
            assign b_inv         = ~b[gi];
            assign diff[gi]      = a[gi] ^ b_inv ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b_inv) | (carry[gi] & (a[gi] ^ b_inv));
        end
    endgenerate

    // No carry out of the top cell means the subtraction wrapped.
    assign borrow = ~carry[REM_WIDTH];

endmodule

// File: rtl/four_bit_divider.sv
// 4-bit unsigned restoring divider: one quotient bit per clock, start/valid handshake.
module four_bit_divider
    import div_pkg::*;
(
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    output logic [WIDTH-1:0] out_Q,
    output logic [WIDTH-1:0] out_R,
    output logic             out_busy,
    output logic             out_valid,
    output logic             out_dbz
);

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     a_reg, b_reg, q_reg;
    logic [WIDTH-1:0]     q_out_reg, r_out_reg;
    logic [REM_WIDTH-1:0] p_reg;
    logic [1:0]           cnt_reg;
    logic                 valid_reg, dbz_reg;

    logic                 accept;
    logic [REM_WIDTH-1:0] p_shift, trial, p_step;
    logic                 bw;

    assign accept  = in_start && (state_reg != RUN);
    assign p_shift = {p_reg[REM_WIDTH-2:0], a_reg[cnt_reg]};
    assign p_step  = bw ? p_shift : trial;

    ripple_subtractor u_sub (
        .a      (p_shift),
        .b      ({1'b0, b_reg}),
        .diff   (trial),
        .borrow (bw)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (in_start) begin
                    state_next = (in_B == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_reg == 2'd0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            q_reg     <= '0;
            p_reg     <= '0;
            cnt_reg   <= 2'd0;
            q_out_reg <= '0;
            r_out_reg <= '0;
            valid_reg <= 1'b0;
            dbz_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= in_A;
            b_reg     <= in_B;
            q_reg     <= '0;
            p_reg     <= '0;
            cnt_reg   <= (in_B == '0) ? 2'd0 : 2'd3;
            valid_reg <= 1'b0;
            dbz_reg   <= 1'b0;
        end else if (state_reg == RUN) begin
            p_reg          <= p_step;
            q_reg[cnt_reg] <= ~bw;
            cnt_reg        <= cnt_reg - 2'd1;
            if (cnt_reg == 2'd0) begin
                q_out_reg <= {q_reg[WIDTH-1:1], ~bw};
                r_out_reg <= p_step[WIDTH-1:0];
                valid_reg <= 1'b1;
            end
        end else if (state_reg == DONE && !valid_reg) begin
            // Only a divide-by-zero acceptance lands in DONE without a result yet.
            q_out_reg <= DBZ_QUOTIENT;
            r_out_reg <= a_reg;
            dbz_reg   <= 1'b1;
            valid_reg <= 1'b1;
        end
    end

    always_comb begin
        out_busy  = (state_reg == RUN);
        out_valid = valid_reg;
        out_dbz   = dbz_reg;
        out_Q     = q_out_reg;
        out_R     = r_out_reg;
    end

endmodule

// File: tb/tb_four_bit_divider.sv
// Self-checking bench: directed cases, full operand sweep and random traffic vs an arithmetic model.
module tb_four_bit_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a_in, b_in;
    logic [3:0] q_out, r_out;
    logic       busy, valid, dbz;

    int checks = 0;
    int errors = 0;

    bit armed = 0;
    int exp_q, exp_r, exp_dbz;

    four_bit_divider dut (
        .in_clk    (clk),
        .in_rst_n  (rst_n),
        .in_start  (start),
        .in_A      (a_in),
        .in_B      (b_in),
        .out_Q     (q_out),
        .out_R     (r_out),
        .out_busy  (busy),
        .out_valid (valid),
        .out_dbz   (dbz)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, quotient all-ones and remainder = A on zero divisor.
    task automatic set_model(input int a, input int b);
        exp_dbz = (b == 0);
        exp_q   = (b == 0) ? 15 : a / b;
        exp_r   = (b == 0) ? a : a % b;
        armed   = 1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_valid_exclusive", int'(busy && valid), 0);
            if (armed && valid) begin
                chk("model_q", int'(q_out), exp_q);
                chk("model_r", int'(r_out), exp_r);
                chk("model_dbz", int'(dbz), exp_dbz);
            end
            if (armed && exp_dbz == 1) chk("dbz_busy", int'(busy), 0);
        end
    end

    task automatic run_div(input logic [3:0] a, input logic [3:0] b, input bit noise);
        int  n;
        bit  got;
        a_in  = a;
        b_in  = b;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        set_model(int'(a), int'(b));
        chk("valid_after_accept", int'(valid), 0);
        chk("busy_after_accept", int'(busy), int'(b != 0));
        if (noise) begin
            a_in = 4'($urandom);
            b_in = 4'($urandom);
        end
        n   = 0;
        got = 0;
        while (!got && n < 8) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) got = 1;
            else if (noise && b != 0) begin
                start = 1'($urandom_range(0, 1));
                a_in  = 4'($urandom);
                b_in  = 4'($urandom);
            end
        end
        start = 0;
        if (!got) chk("valid_timeout", 0, 1);
        else chk("latency", n, (b == 0) ? 1 : 4);
        $display("div %0d/%0d -> Q=%0d R=%0d dbz=%0d cycles=%0d", a, b, q_out, r_out, dbz, n);
    endtask

    task automatic directed(input logic [3:0] a, input logic [3:0] b, input int eq, input int er);
        run_div(a, b, 0);
        chk("lit_valid", int'(valid), 1);
        chk("lit_q", int'(q_out), eq);
        chk("lit_r", int'(r_out), er);
        chk("lit_dbz", int'(dbz), int'(b == 0));
    endtask

    initial begin
        rst_n = 0;
        start = 0;
        a_in  = 0;
        b_in  = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", int'(q_out), 0);
        chk("rst_r", int'(r_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_dbz", int'(dbz), 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("idle_valid", int'(valid), 0);
        chk("idle_busy", int'(busy), 0);

        // Reset asserted mid-run, between clock edges.
        a_in  = 13;
        b_in  = 3;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        chk("run_busy", int'(busy), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_q", int'(q_out), 0);
        chk("async_rst_r", int'(r_out), 0);
        chk("async_rst_dbz", int'(dbz), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        directed(9, 4, 2, 1);

        directed(13, 3, 4, 1);
        directed(15, 1, 15, 0);
        directed(2, 9, 0, 2);
        directed(0, 5, 0, 0);
        directed(15, 15, 1, 0);
        directed(7, 0, 15, 7);

        // Start pulse during RUN with different operands must be ignored.
        a_in  = 14;
        b_in  = 4;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        set_model(14, 4);
        @(posedge clk);
        #1;
        start = 1;
        a_in  = 1;
        b_in  = 1;
        @(posedge clk);
        #1;
        start = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("ignore_valid", int'(valid), 1);
        chk("ignore_q", int'(q_out), 3);
        chk("ignore_r", int'(r_out), 2);
        $display("div 14/4 with ignored start -> Q=%0d R=%0d", q_out, r_out);

        // Each run_div starts in the cycle the previous result appeared: back-to-back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(4'(a), 4'(b), 1);
            end
        end

        for (int k = 0; k < 64; k++) begin
            run_div(4'($urandom), 4'($urandom), 1);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bit_divider.md
Name: four_bit_divider

Overview:
Sequential 4-bit unsigned restoring divider, the inverse arithmetic operation to the team's ripple-carry adder datapath. It computes quotient and remainder by iterated trial subtraction, one quotient bit per clock. A start/valid handshake connects it to a controller. The subtract stage is a ripple-borrow subtractor built from the same full-adder cell style as the adder.

Parameters:
None. The width is fixed at 4 bits, matching the adder family.

Ports:
in_clk      input   1  system clock, rising-edge
in_rst_n    input   1  asynchronous active-low reset
in_start    input   1  request a division; sampled on the rising edge
in_A        input   4  dividend (unsigned)
in_B        input   4  divisor (unsigned)
out_Q       output  4  quotient
out_R       output  4  remainder
out_busy    output  1  high while an iteration sequence is in progress
out_valid   output  1  out_Q/out_R/out_dbz hold a completed result
out_dbz     output  1  divide-by-zero flag for the current result

Behaviour:
- One clock, in_clk. Reset is asynchronous and active-low on in_rst_n.
- Reset, asserted at any time including mid-operation: state=IDLE, out_Q=0, out_R=0, out_busy=0, out_valid=0, out_dbz=0, step counter=0. Any in-flight operation is discarded.
- States: IDLE, RUN, DONE. Encoding uses 2 bits and lives in the package.
- Start acceptance (edge E0): in_start=1 while in IDLE or DONE. In RUN, in_start is ignored.
- On acceptance:
  - Latch in_A and in_B into internal registers.
  - Clear the 5-bit partial remainder P and the quotient.
  - Force out_valid=0 and out_dbz=0.
- Divide-by-zero at acceptance (in_B==0):
  - Next state is DONE.
  - Registered results are out_Q=4'hF, out_R=latched in_A, out_dbz=1.
  - out_valid=1 from E1.
  - out_busy never asserts.
- Normal case at acceptance: next state RUN, out_busy=1, step counter i=3.
- RUN iteration, one per edge E1..E4, for i=3,2,1,0:
  - P' = {P[3:0], A[i]}.
  - T = P' - {0,B}, computed as a 5-bit subtraction with borrow-out bw.
  - If bw=0: P=T and Q[i]=1. Otherwise P=P' and Q[i]=0.
  - i decrements.
- Leaving RUN: at E4 (after the i=0 step) the state moves to DONE, out_busy=0, out_valid=1, out_Q=Q, out_R=P[3:0].
- Latency: the result is visible after E4, which is 4 cycles after acceptance.
- Width rule: P never exceeds 2*B-1 ≤ 29, so 5 bits suffice. P[4] is always 0 in DONE.
- DONE holds all outputs stable until the next accepted start or reset.
- A new start in DONE is accepted back-to-back, with no IDLE cycle required.
- in_A and in_B may change freely after E0; only the latched copies are used.
- Invariants:
  - out_busy and out_valid are never high together.
  - out_Q*B + out_R == A, and out_R < B, whenever out_valid=1 and out_dbz=0.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE=0, RUN=1, DONE=2);
  - WIDTH=4;
  - REM_WIDTH=5;
  - DBZ_QUOTIENT=4'hF.
- Sub-module ripple_subtractor, a 5-bit A-B ripple-borrow chain. Each bit is a full-adder-style cell with inverted B and carry-in=1. It outputs the difference and the borrow.
- The FSM, counter and registers live in four_bit_divider.

Test Plan:
- Reset during RUN:
  - in_A=13, in_B=3, start; deassert in_rst_n after E2 → all outputs 0 asynchronously.
  - After release, a 9/4 start → out_Q=2, out_R=1.
- Basic divide: in_A=13, in_B=3, start pulse → out_busy high E0–E4. out_valid=1 after E4 with out_Q=4, out_R=1, out_dbz=0.
- Extremes:
  - 15/1 → Q=15, R=0.
  - 2/9 → Q=0, R=2.
  - 0/5 → Q=0, R=0.
  - 15/15 → Q=1, R=0.
- Divide by zero: in_A=7, in_B=0 → out_valid=1 and out_dbz=1 after E1, out_Q=4'hF, out_R=7, out_busy never high.
- Start during RUN ignored:
  - 14/4 started.
  - At E2, in_start=1 with in_A=1, in_B=1.
  - Result after E4 is still Q=3, R=2.
- Back-to-back and exhaustive:
  - Start again in the same cycle out_valid rises → out_valid drops, and the new result arrives 4 cycles later.
  - Sweep all 256 (A,B) pairs against the reference model, including the dbz rule.
